// File: rtl/ehl_apb_master.sv
// APB initiator: one generic-bus request at a time becomes one APB SETUP/ACCESS transfer.
// Optional macro EHL_APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT wait cycles.
//
// state  | meaning
// IDLE   | no transfer; request accepted here; ack pulses here after a completion
// SETUP  | psel=1, penable=0, one cycle
// ACCESS | psel=1, penable=1, waiting for pready (or timeout when enabled)
module ehl_apb_master #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADR_WIDTH-1:0]  adr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADR_WIDTH-1:0]  paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;

`ifdef EHL_APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  // Counts down the wait cycles still allowed; terminal count 1 means this is the last one.
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rdata   <= '0;
`ifdef EHL_APB_MASTER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            paddr  <= adr;
            pwrite <= we;
            pwdata <= wdata;
            psel   <= 1'b1;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef EHL_APB_MASTER_TIMEOUT_EN
          wait_cnt <= CW'(TIMEOUT);
`endif
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            err     <= pslverr;
            if (!pwrite) rdata <= prdata;
            state   <= IDLE;
          end
`ifdef EHL_APB_MASTER_TIMEOUT_EN
          else if (wait_cnt == CW'(1)) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ehl_apb_master.md
Name: ehl_apb_master

Overview:
APB initiator that converts a simple single-request generic bus into AMBA APB (v2/v3 with pready/pslverr) transfers. It is the initiator for the team's APB-slave peripherals and memories, such as APB-wrapped SPRAMs and register banks. It sits between a CPU/DMA-side request port and an APB segment with one outstanding transfer at a time. Returns read data and error status with a one-cycle completion pulse.

Parameters:
ADR_WIDTH, 32, width of request address and paddr
DATA_WIDTH, 32, width of wdata/rdata/pwdata/prdata
TIMEOUT, 255, max ACCESS-phase wait cycles before forced abort (used only with EHL_APB_MASTER_TIMEOUT_EN); legal 1..65535

Ports:
pclk  in  1  clock; all logic on rising edge
presetn  in  1  asynchronous active-low reset
req  in  1  request strobe; sampled only when busy=0
we  in  1  request direction: 1 write, 0 read
adr  in  ADR_WIDTH  request byte address
wdata  in  DATA_WIDTH  request write data
busy  out  1  transfer in progress (SETUP or ACCESS)
ack  out  1  one-cycle completion pulse
rdata  out  DATA_WIDTH  captured read data
err  out  1  completion status; valid with ack
paddr  out  ADR_WIDTH  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  APB slave ready
pslverr  in  1  APB slave error
prdata  in  DATA_WIDTH  APB read data

Behaviour:
- Reset: state=IDLE; psel, penable, pwrite, busy, ack, err = 0; paddr, pwdata, rdata = 0. Asserting presetn low mid-transfer immediately (asynchronously) drops psel/penable with no ack.
- FSM states: IDLE, SETUP, ACCESS; all outputs registered.
- IDLE: psel=0, penable=0, busy=0. If req=1, register adr->paddr, we->pwrite, wdata->pwdata and go to SETUP.
- SETUP (one cycle): psel=1, penable=0, busy=1. Go to ACCESS unconditionally.
- ACCESS: psel=1, penable=1, busy=1. If pready=0, stay (wait state). If pready=1, go to IDLE. At that edge, register ack=1 and err=pslverr. If pwrite=0, also register rdata=prdata.
- ack is high for exactly one cycle, the first IDLE cycle after completion. err holds until the next completion. rdata is updated only by reads, including errored reads, and holds otherwise.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS and hold their values after the transfer until the next accepted req.
- Latency: req at cycle N -> SETUP at N+1 -> ACCESS at N+2 -> ack at N+3 + (number of wait cycles). Minimum 3 cycles; maximum back-to-back throughput is one transfer per 3 cycles.
- req while busy=1 is ignored; it is not queued. req during the ack cycle (IDLE) is accepted.
- pready/pslverr/prdata are ignored outside ACCESS.
- No psel is ever asserted without a preceding accepted req.

Optional Feature:
EHL_APB_MASTER_TIMEOUT_EN:
- Defined: a wait counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
- When the counter reaches TIMEOUT while pready is still 0, the transfer is aborted: next state is IDLE (psel/penable drop), ack=1, err=1, and rdata is unchanged.
- pready=1 on the same cycle the counter reaches TIMEOUT counts as normal completion.
- Undefined: no counter exists; ACCESS waits indefinitely for pready.

Test Plan:
1. Write: req=1, we=1, adr=0x10, wdata=0xDEADBEEF, slave pready=1 -> psel at +1, penable at +2, paddr=0x10 and pwdata=0xDEADBEEF stable, ack=1 and err=0 at +3, busy low at +3.
2. Read with 2 wait states: adr=0x24, prdata=0x12345678 presented with pready on the 3rd ACCESS cycle -> ack at +5, rdata=0x12345678, err=0.
3. Slave error: read with pslverr=1 and prdata=0xA5A5A5A5 -> ack=1, err=1, rdata=0xA5A5A5A5. A following write with pslverr=0 -> err=0 and rdata still 0xA5A5A5A5.
4. req pulses during SETUP/ACCESS -> no extra transfer. req asserted on the ack cycle -> new SETUP on the next cycle.
5. Timeout, with EHL_APB_MASTER_TIMEOUT_EN and TIMEOUT=4: pready held 0 -> abort after 4 wait cycles with ack=1, err=1, psel=0. Without the macro -> psel stays 1 for 100+ cycles.
6. Reset mid-ACCESS: presetn=0 with penable=1 -> psel/penable/busy=0 immediately and no ack. After release, req=1 performs a normal transfer.
